// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : piso_serializer
// Purpose  : Parallel-in, serial-out transmitter. It accepts a word over a
//            valid/ready handshake and sends it one bit per clock, with
//            first and last strobes.
// Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

  localparam int                c_cnt_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]     r_shift;
  logic [WIDTH-1:0]     w_shift_nxt;
  logic                 r_ser_out;
  logic                 r_ser_valid;
  logic                 r_ser_first;
  logic                 r_ser_last;
  logic                 w_accept;
  logic                 w_bit_nxt;
  logic                 w_at_last;

  assign w_at_last = (r_state == S_SHIFT) && (r_cnt == c_last);
  assign in_ready  = !reset && ((r_state == S_IDLE) || w_at_last);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_shift_nxt = in_data;
        end
      end
      S_SHIFT: begin
        if (!w_at_last) begin
          w_cnt_nxt   = r_cnt + 1'b1;
          w_shift_nxt = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);
        end else if (w_accept) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = in_data;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_shift_nxt = '0;
      end
    endcase
  end

  // The bit presented after an edge is the head of the register loaded at that edge.
  assign w_bit_nxt = LSB_FIRST ? w_shift_nxt[0] : w_shift_nxt[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_ser_first <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_ser_out   <= (w_state_nxt == S_SHIFT) && w_bit_nxt;
      r_ser_valid <= (w_state_nxt == S_SHIFT);
      r_ser_first <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == '0);
      r_ser_last  <= (w_state_nxt == S_SHIFT) && (w_cnt_nxt == c_last);
    end
  end

  assign ser_out   = r_ser_out;
  assign ser_valid = r_ser_valid;
  assign ser_first = r_ser_first;
  assign ser_last  = r_ser_last;
  assign busy      = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_serializer
// Purpose  : Bench for piso_serializer; LSB-first and MSB-first instances
//            share stimulus and are compared against a bit-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;

  logic rdy_a, out_a, val_a, fst_a, lst_a, bsy_a;
  logic rdy_b, out_b, val_b, fst_b, lst_b, bsy_b;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_a), .ser_out(out_a), .ser_valid(val_a),
    .ser_first(fst_a), .ser_last(lst_a), .busy(bsy_a)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_b), .ser_out(out_b), .ser_valid(val_b),
    .ser_first(fst_b), .ser_last(lst_b), .busy(bsy_b)
  );

  // Each queue entry is one future serial cycle: {bit, first, last}.
  typedef struct packed {
    logic b;
    logic f;
    logic l;
  } ent_t;

  ent_t q_lsb[$];
  ent_t q_msb[$];
  int   errors = 0;
  int   checks = 0;
  bit   acc_flag = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    ent_t ea;
    ent_t eb;
    logic va;
    logic vb;
    logic er;
    ea = '0;
    eb = '0;
    va = (q_lsb.size() > 0);
    vb = (q_msb.size() > 0);
    if (va) ea = q_lsb[0];
    if (vb) eb = q_msb[0];
    er = !reset && (q_lsb.size() <= 1);
    chk("in_ready_lsb", rdy_a, er);
    chk("in_ready_msb", rdy_b, er);
    chk("ser_valid_lsb", val_a, va);
    chk("ser_out_lsb", out_a, ea.b);
    chk("ser_first_lsb", fst_a, ea.f);
    chk("ser_last_lsb", lst_a, ea.l);
    chk("busy_lsb", bsy_a, va);
    chk("ser_valid_msb", val_b, vb);
    chk("ser_out_msb", out_b, eb.b);
    chk("ser_first_msb", fst_b, eb.f);
    chk("ser_last_msb", lst_b, eb.l);
    chk("busy_msb", bsy_b, vb);
  endtask

  // Model: a word accepted at an edge appends its W bits to the stream.
  task automatic model_edge();
    bit acc;
    acc = in_valid && !reset && (q_lsb.size() <= 1);
    acc_flag = acc;
    if (reset) begin
      q_lsb.delete();
      q_msb.delete();
    end else begin
      if (q_lsb.size() > 0) void'(q_lsb.pop_front());
      if (q_msb.size() > 0) void'(q_msb.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          q_lsb.push_back('{b: in_data[i],       f: (i == 0), l: (i == W - 1)});
          q_msb.push_back('{b: in_data[W-1-i],   f: (i == 0), l: (i == W - 1)});
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send(input logic [W-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!acc_flag && n < 3 * W);
    if (!acc_flag) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted data=%h", d);
    end
    in_valid = 1'b0;
    in_data  = 'x;
  endtask

  initial begin
    // Reset held with a word waiting; first edge after release accepts it.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hC1;
    @(posedge clk);
    model_edge();
    #1;
    run(3);
    reset = 1'b0;
    cycle();
    in_valid = 1'b0;
    in_data  = 'x;
    run(W + 2);

    // Single word in both bit orders.
    send(8'hC1);
    run(W + 2);

    // Back-to-back words with in_valid held high.
    in_valid = 1'b1;
    in_data  = 8'hC1;
    do cycle(); while (!acc_flag);
    in_data = 8'h0F;
    do cycle(); while (!acc_flag);
    in_valid = 1'b0;
    in_data  = 'x;
    run(W + 2);

    // Mid-word valid pulses and data changes must be ignored.
    send(8'h3C);
    cycle();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    cycle();
    in_data  = 8'h00;
    cycle();
    cycle();
    in_valid = 1'b0;
    in_data  = 'x;
    run(W + 2);

    // Reset in the middle of a word drops it.
    send(8'h5A);
    run(2);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    send(8'hA5);
    run(W + 2);

    // Random traffic with occasional resets and X data while idle.
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      if (in_valid || $urandom_range(0, 1) == 0) in_data = W'($urandom);
      else in_data = 'x;
      cycle();
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    run(W + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
